key_event_encoder: RTL and testbench
====================================

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter NUM_KEYS, 13, number of keyboard inputs (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, 250000, clk cycles a raw key level must hold before it is accepted (>=2).
REQ-003 Parameter FREQ_W, 32, width of each half-period count output.
REQ-004 Port clk  input  1  system clock, the only clock.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port KEYBOARD  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed.
REQ-007 Port scale  input  3  octave shift, sampled every cycle.
REQ-008 Port noteFrequency  output  NUM_KEYS x FREQ_W  per-key half-period count, 0 = silent.
REQ-009 Port inputData  output  10  serial frame: {stop=1, code[7:0], start=0}.
REQ-010 Port ivalid  output  1  inputData holds a valid frame.
REQ-011 Port iready  input  1  downstream accepts the frame when ivalid && iready.
REQ-012 Port LED  output  8  status: [7] out of reset, [6] no key held, [5] event dropped (sticky), [4:3] 0, [2:0] scale.

Function
REQ-013 Each KEYBOARD bit passes through a 2-flop synchroniser, then through a debounce counter; the debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles, and the counter clears on any match.
REQ-014 A 0->1 debounced transition sets press_pend[i]; a 1->0 transition sets rel_pend[i].
REQ-015 A new edge on key i with the opposite pending flag still set clears that flag, so only the latest event is kept, and sets LED[5].
REQ-016 noteFrequency[i] = NOTE_TABLE[i] >> scale (registered, 1-cycle latency) while debounced key i is 1; otherwise 0.
REQ-017 The frame FSM has states IDLE, LOAD and HOLD.
REQ-018 IDLE: if any flag is pending, go to LOAD. The arbiter selects the lowest-index key with a pending flag; press takes precedence over release for the same key.
REQ-019 LOAD (one cycle): register inputData; code = KEY_TABLE[i] for a press and KEY_TABLE[i] | 8'h80 for a release; clear the selected flag; set ivalid; go to HOLD.
REQ-020 HOLD: inputData and ivalid stay stable until ivalid && iready; on that cycle ivalid drops next cycle and the FSM returns to IDLE.
REQ-021 Latency: a debounced edge produces ivalid exactly 2 cycles later when the FSM is IDLE; peak throughput is 1 frame per 3 cycles.
REQ-022 An edge arriving during LOAD or HOLD is latched in the pending flags and never lost, except as allowed by REQ-015.
REQ-023 If iready is high in the same cycle ivalid first rises, the frame completes in that cycle.
REQ-024 When ivalid = 0, inputData = 10'h3FF (idle line level).
REQ-025 LED[6] = 1 when no debounced key is 1.
REQ-026 LED[2:0] = scale; LED[7] = 1 whenever reset is low.

Reset
REQ-027 While reset is high: synchronisers, debounced levels, counters and pending flags are 0; FSM is IDLE; ivalid = 0; inputData = 10'h3FF; noteFrequency all 0; LED[7:3] = 0.
REQ-028 Reset asserted mid-HOLD aborts the frame with no handshake. After release, keys still physically held re-debounce and emit fresh press frames.

Structure
REQ-029 Package key_pkg holds NOTE_TABLE (13 x 32-bit: 95556, 101238, 107258, 113636, 120394, 127553, 135137, 143173, 151686, 160706, 170262, 180387, 191113), KEY_TABLE (13 ASCII bytes), START_BIT, STOP_BIT, IDLE_FRAME and the FSM state enum.
REQ-030 One sub-module, key_debounce (synchroniser plus counter for one key, parameter DEBOUNCE_CYCLES), instantiated NUM_KEYS times by a generate loop.
REQ-031 Compile-time assertions reject NUM_KEYS > 13 unless the tables are extended.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 KEYBOARD[0] high, steady, iready=1 -> ivalid pulses once ~8 cycles later with inputData = {1, KEY_TABLE[0], 0}; noteFrequency[0] = 95556 >> scale.
REQ-033 KEYBOARD[3] glitches high for 3 cycles -> no frame; noteFrequency[3] stays 0.
REQ-034 Keys 2 and 5 pressed in the same cycle, iready=0 for 10 cycles -> inputData stays stable with key 2's code; after iready=1, key 5's frame follows 3 cycles later.
REQ-035 Key 1 pressed then released with iready held low -> only a release frame (code | 8'h80) is emitted; LED[5] = 1.
REQ-036 reset asserted during HOLD with key 4 held -> ivalid = 0 and inputData = 3FF immediately; after release, one press frame for key 4.
REQ-037 scale swept 0..7 with key 12 held -> noteFrequency[12] = 191113 >> scale, updated 1 cycle after each change.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants, tables and types for key_event_encoder.
// Holds note half-period table, key code table, frame framing bits, FSM enum.
package key_pkg;

  localparam int NUM_NOTES = 13;

  localparam logic       START_BIT  = 1'b0;
  localparam logic       STOP_BIT   = 1'b1;
  localparam logic [9:0] IDLE_FRAME = 10'h3FF;

  // Half-period counts for the base octave, one per key.
  localparam logic [31:0] NOTE_TABLE [NUM_NOTES] = '{
    32'd95556,  32'd101238, 32'd107258, 32'd113636,
    32'd120394, 32'd127553, 32'd135137, 32'd143173,
    32'd151686, 32'd160706, 32'd170262, 32'd180387,
    32'd191113
  };

  // ASCII codes: a w s e d f t g y h u j k (piano row).
  localparam logic [7:0] KEY_TABLE [NUM_NOTES] = '{
    8'h61, 8'h77, 8'h73, 8'h65, 8'h64, 8'h66, 8'h74,
    8'h67, 8'h79, 8'h68, 8'h75, 8'h6A, 8'h6B
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD
  } frame_state_e;

  function automatic logic [9:0] make_frame(
    input logic [7:0] code
  );
    return {STOP_BIT, code, START_BIT};
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Frame handshake bundle between encoder and serial consumer.
// inputData/ivalid from master, iready from slave.
interface key_event_encoder_if;

  logic [9:0] inputData;
  logic       ivalid;
  logic       iready;

  modport master (
    output inputData,
    output ivalid,
    input  iready
  );

  modport slave (
    input  inputData,
    input  ivalid,
    output iready
  );

endinterface

// File: rtl/key_debounce.sv
// One-key 2-flop synchroniser plus debounce counter.
// Ports: clk, reset, key_raw in; level, rise, fall (1-cycle pulses) out.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          lvl_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          flip;

  always_comb begin
    flip  = (s2_q != lvl_q) && (cnt_q == LAST);
    cnt_d = '0;
    lvl_d = lvl_q;
    if (s2_q != lvl_q) begin
      if (flip) lvl_d = s2_q;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= key_raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign rise  = flip & s2_q;
  assign fall  = flip & ~s2_q;

endmodule

// File: rtl/key_event_encoder.sv
// Debounces a key row, emits press/release frames, drives note periods.
// Ports: clk, reset, KEYBOARD, scale, noteFrequency, LED, fr (frame bus).
module key_event_encoder
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 13,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FREQ_W          = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_KEYS-1:0]              KEYBOARD,
  input  logic [2:0]                       scale,
  output logic [NUM_KEYS-1:0][FREQ_W-1:0]  noteFrequency,
  output logic [7:0]                       LED,
  key_event_encoder_if.master              fr
);

  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  if (NUM_KEYS > NUM_NOTES || NUM_KEYS < 1) begin : g_bad_keys
    $error("NUM_KEYS outside note/key table range");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [NUM_KEYS-1:0] db;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .key_raw (KEYBOARD[g]),
      .level   (db[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

  frame_state_e        state_q;
  logic [9:0]          frame_q;
  logic                valid_q;
  logic [NUM_KEYS-1:0] press_pend_q;
  logic [NUM_KEYS-1:0] press_pend_d;
  logic [NUM_KEYS-1:0] rel_pend_q;
  logic [NUM_KEYS-1:0] rel_pend_d;
  logic                drop_q;
  logic                drop_d;
  logic [NUM_KEYS-1:0][FREQ_W-1:0] note_q;
  logic [NUM_KEYS-1:0][FREQ_W-1:0] note_d;

  logic          any_pend;
  logic [KW-1:0] sel_idx;
  logic          sel_rel;
  logic [7:0]    sel_code;

  // Lowest index wins; a pending press beats a release on the same key.
  always_comb begin
    any_pend = |(press_pend_q | rel_pend_q);
    sel_idx  = '0;
    sel_rel  = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_pend_q[i] | rel_pend_q[i]) begin
        sel_idx = KW'(i);
        sel_rel = ~press_pend_q[i];
      end
    end
    sel_code = KEY_TABLE[sel_idx];
    if (sel_rel) sel_code = sel_code | 8'h80;
  end

  // The LOAD clear is applied first so a fresh edge on the same key
  // re-arms its flag and is not counted as a dropped event.
  always_comb begin
    press_pend_d = press_pend_q;
    rel_pend_d   = rel_pend_q;
    drop_d       = drop_q;
    if (state_q == S_LOAD && any_pend) begin
      if (sel_rel) rel_pend_d[sel_idx]   = 1'b0;
      else         press_pend_d[sel_idx] = 1'b0;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) begin
        if (rel_pend_d[i]) drop_d = 1'b1;
        rel_pend_d[i]   = 1'b0;
        press_pend_d[i] = 1'b1;
      end
      if (fall[i]) begin
        if (press_pend_d[i]) drop_d = 1'b1;
        press_pend_d[i] = 1'b0;
        rel_pend_d[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    note_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (db[i]) note_d[i] = FREQ_W'(NOTE_TABLE[i] >> scale);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      drop_q       <= 1'b0;
      note_q       <= '0;
    end else begin
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      drop_q       <= drop_d;
      note_q       <= note_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      frame_q <= IDLE_FRAME;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_pend) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (any_pend) begin
            frame_q <= make_frame(sel_code);
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (fr.iready) begin
            frame_q <= IDLE_FRAME;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fr.inputData  = frame_q;
  assign fr.ivalid     = valid_q;
  assign noteFrequency = note_q;
  assign LED = {~reset, ~reset & ~(|db), drop_q, 2'b00, scale};

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with DEBOUNCE_CYCLES=4.
// Hand-computed frames and note values; one summary line at the end.
module tb_key_event_encoder;

  logic             clk = 1'b0;
  logic             reset;
  logic [12:0]      kb;
  logic [2:0]       scale;
  logic [12:0][31:0] nf;
  logic [7:0]       led;
  logic [9:0]       frames [$];
  logic [9:0]       d0;
  int               n;
  int               n_vec = 0;
  int               n_err = 0;
  bit               flag;

  key_event_encoder_if bus ();

  key_event_encoder #(
    .NUM_KEYS        (13),
    .DEBOUNCE_CYCLES (4),
    .FREQ_W          (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .KEYBOARD      (kb),
    .scale         (scale),
    .noteFrequency (nf),
    .LED           (led),
    .fr            (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_valid(input string tag, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (bus.ivalid) return;
    end
    check(tag, 32'd0, 32'd1);
  endtask

  // Record every frame handed over while iready is high.
  task automatic collect(input int k);
    frames.delete();
    for (int i = 0; i < k; i++) begin
      if (bus.ivalid && bus.iready) frames.push_back(bus.inputData);
      tick();
    end
  endtask

  localparam logic [31:0] K12_NOTE [8] = '{
    32'd191113, 32'd95556, 32'd47778, 32'd23889,
    32'd11944,  32'd5972,  32'd2986,  32'd1493
  };

  initial begin
    reset      = 1'b1;
    kb         = '0;
    scale      = 3'd0;
    bus.iready = 1'b0;
    ticks(2);
    check("rst_valid", 32'(bus.ivalid), 32'd0);
    check("rst_data", 32'(bus.inputData), 32'h3FF);
    check("rst_led", 32'(led), 32'h00);
    check("rst_note", nf[0], 32'd0);
    reset = 1'b0;
    tick();
    check("led_idle", 32'(led), 32'hC0);

    // key 0 press, iready high
    scale      = 3'd2;
    bus.iready = 1'b1;
    kb[0]      = 1'b1;
    wait_valid("to_k0", n);
    check("lat_k0", 32'(n), 32'd8);
    check("frm_k0", 32'(bus.inputData), 32'h2C2);
    check("note_k0", nf[0], 32'd23889);
    check("led6_held", 32'(led[6]), 32'd0);
    tick();
    check("ack_valid", 32'(bus.ivalid), 32'd0);
    check("ack_data", 32'(bus.inputData), 32'h3FF);

    // key 0 release
    kb[0] = 1'b0;
    wait_valid("to_r0", n);
    check("frm_r0", 32'(bus.inputData), 32'h3C2);
    tick();
    check("led6_free", 32'(led[6]), 32'd1);
    check("note_r0", nf[0], 32'd0);

    // key 3 glitch of 3 cycles
    kb[3] = 1'b1;
    ticks(3);
    kb[3] = 1'b0;
    flag  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ivalid || nf[3] != 0) flag = 1'b1;
    end
    check("glitch", 32'(flag), 32'd0);

    // keys 2 and 5 together, iready low
    bus.iready = 1'b0;
    kb[2] = 1'b1;
    kb[5] = 1'b1;
    wait_valid("to_k2", n);
    check("frm_k2", 32'(bus.inputData), 32'h2E6);
    d0   = bus.inputData;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.ivalid || bus.inputData != d0) flag = 1'b1;
    end
    check("hold_k2", 32'(flag), 32'd0);
    bus.iready = 1'b1;
    tick();
    check("drop_k2", 32'(bus.ivalid), 32'd0);
    wait_valid("to_k5", n);
    check("gap_k5", 32'(n), 32'd2);
    check("frm_k5", 32'(bus.inputData), 32'h2CC);
    kb[2] = 1'b0;
    kb[5] = 1'b0;
    ticks(30);
    check("no_drop", 32'(led[5]), 32'd0);

    // key 1 press+release while key 0 frame stalls
    bus.iready = 1'b0;
    kb[0] = 1'b1;
    wait_valid("to_k0b", n);
    check("frm_k0b", 32'(bus.inputData), 32'h2C2);
    kb[1] = 1'b1;
    ticks(10);
    kb[1] = 1'b0;
    ticks(10);
    check("led5_drop", 32'(led[5]), 32'd1);
    bus.iready = 1'b1;
    collect(30);
    check("n_k1", 32'(frames.size()), 32'd2);
    if (frames.size() == 2) begin
      check("frm_a", 32'(frames[0]), 32'h2C2);
      check("frm_r1", 32'(frames[1]), 32'h3EE);
    end
    kb[0] = 1'b0;
    ticks(30);

    // reset during HOLD with key 4 held
    bus.iready = 1'b0;
    kb[4] = 1'b1;
    wait_valid("to_k4", n);
    check("frm_k4", 32'(bus.inputData), 32'h2C8);
    reset = 1'b1;
    #1;
    check("rh_valid", 32'(bus.ivalid), 32'd0);
    check("rh_data", 32'(bus.inputData), 32'h3FF);
    check("rh_led", 32'(led & 8'hF8), 32'h00);
    ticks(3);
    reset      = 1'b0;
    bus.iready = 1'b1;
    collect(30);
    check("n_k4", 32'(frames.size()), 32'd1);
    if (frames.size() == 1)
      check("frm_k4b", 32'(frames[0]), 32'h2C8);
    check("led5_clr", 32'(led[5]), 32'd0);
    kb[4] = 1'b0;
    ticks(30);

    // scale sweep on key 12
    scale  = 3'd0;
    kb[12] = 1'b1;
    ticks(20);
    check("note_k12", nf[12], K12_NOTE[0]);
    for (int s = 1; s < 8; s++) begin
      scale = 3'(s);
      #1;
      check("led_scale", 32'(led[2:0]), 32'(s));
      check("note_old", nf[12], K12_NOTE[s-1]);
      tick();
      check("note_new", nf[12], K12_NOTE[s]);
    end
    kb[12] = 1'b0;
    ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
